// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded instruction, bypass sources, and the
// registered ALU and memory-stage fields returned by id_ex_stage.
interface id_ex_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  dec_valid_in;
  logic                  dec_ready_out;
  logic [3:0]            dec_alu_op_in;
  logic [REG_ADDR_W-1:0] dec_rs1_in;
  logic [REG_ADDR_W-1:0] dec_rs2_in;
  logic                  dec_rs1_used_in;
  logic                  dec_rs2_used_in;
  logic [XLEN-1:0]       dec_rs1_data_in;
  logic [XLEN-1:0]       dec_rs2_data_in;
  logic [XLEN-1:0]       dec_imm_in;
  logic [XLEN-1:0]       dec_pc_in;
  logic                  dec_op1_sel_in;
  logic                  dec_op2_sel_in;
  logic [REG_ADDR_W-1:0] dec_rd_in;
  logic                  dec_reg_wr_in;
  logic                  dec_is_load_in;
  logic                  flush_in;
  logic                  ex_ready_in;
  logic [XLEN-1:0]       alu_result_in;
  logic [REG_ADDR_W-1:0] mem_rd_in;
  logic                  mem_reg_wr_in;
  logic [XLEN-1:0]       mem_data_in;
  logic [REG_ADDR_W-1:0] wb_rd_in;
  logic                  wb_reg_wr_in;
  logic [XLEN-1:0]       wb_data_in;
  logic                  ex_valid_out;
  logic [3:0]            alu_opcode_out;
  logic [XLEN-1:0]       alu_op_1_out;
  logic [XLEN-1:0]       alu_op_2_out;
  logic [XLEN-1:0]       ex_store_data_out;
  logic [REG_ADDR_W-1:0] ex_rd_out;
  logic                  ex_reg_wr_out;
  logic                  ex_is_load_out;
  logic                  load_use_stall_out;

  modport master (
    output dec_valid_in, dec_alu_op_in, dec_rs1_in, dec_rs2_in,
           dec_rs1_used_in, dec_rs2_used_in, dec_rs1_data_in, dec_rs2_data_in,
           dec_imm_in, dec_pc_in, dec_op1_sel_in, dec_op2_sel_in, dec_rd_in,
           dec_reg_wr_in, dec_is_load_in, flush_in, ex_ready_in, alu_result_in,
           mem_rd_in, mem_reg_wr_in, mem_data_in, wb_rd_in, wb_reg_wr_in, wb_data_in,
    input  dec_ready_out, ex_valid_out, alu_opcode_out, alu_op_1_out, alu_op_2_out,
           ex_store_data_out, ex_rd_out, ex_reg_wr_out, ex_is_load_out,
           load_use_stall_out
  );

  modport slave (
    input  dec_valid_in, dec_alu_op_in, dec_rs1_in, dec_rs2_in,
           dec_rs1_used_in, dec_rs2_used_in, dec_rs1_data_in, dec_rs2_data_in,
           dec_imm_in, dec_pc_in, dec_op1_sel_in, dec_op2_sel_in, dec_rd_in,
           dec_reg_wr_in, dec_is_load_in, flush_in, ex_ready_in, alu_result_in,
           mem_rd_in, mem_reg_wr_in, mem_data_in, wb_rd_in, wb_reg_wr_in, wb_data_in,
    output dec_ready_out, ex_valid_out, alu_opcode_out, alu_op_1_out, alu_op_2_out,
           ex_store_data_out, ex_rd_out, ex_reg_wr_out, ex_is_load_out,
           load_use_stall_out
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode->execute register: resolves EX/MEM/WB bypassing and load-use
// hazards, then presents registered opcode and operands to the ALU.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk_in,
  input logic          reset_n_in,
  id_ex_stage_if.slave bus
);

  localparam logic [3:0] OP_NOP = 4'b0000;

  logic                  vld_p0;
  logic [3:0]            opcode_p0;
  logic [XLEN-1:0]       op1_p0;
  logic [XLEN-1:0]       op2_p0;
  logic [XLEN-1:0]       store_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic                  reg_wr_p0;
  logic                  is_load_p0;

  logic                  ex_fwd_en;
  logic                  load_use;
  logic                  take_bubble;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;
  logic [XLEN-1:0]       op1_nxt;
  logic [XLEN-1:0]       op2_nxt;

  // Youngest producer wins; x0 is hard-wired and never bypassed.
  function automatic logic [XLEN-1:0] forward(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_en,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_data,
    input logic                  mem_en,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]       mem_data,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_data
  );
    logic [XLEN-1:0] val;
    val = rf_data;
    if (rs != '0) begin
      if (ex_en && (rs == ex_rd))        val = ex_data;
      else if (mem_en && (rs == mem_rd)) val = mem_data;
      else if (wb_en && (rs == wb_rd))   val = wb_data;
    end
    return val;
  endfunction

  function automatic logic src_hits(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd
  );
    return used && (rs == rd);
  endfunction

  // A load in EX has no data yet, so it cannot feed the EX bypass.
  assign ex_fwd_en = vld_p0 & reg_wr_p0 & ~is_load_p0;

  always_comb begin
    load_use = 1'b0;
    if (bus.dec_valid_in && vld_p0 && is_load_p0 && reg_wr_p0 && (rd_p0 != '0)) begin
      load_use = src_hits(bus.dec_rs1_used_in, bus.dec_rs1_in, rd_p0) |
                 src_hits(bus.dec_rs2_used_in, bus.dec_rs2_in, rd_p0);
    end
  end

  always_comb begin
    fwd_rs1 = forward(bus.dec_rs1_in, bus.dec_rs1_data_in,
                      ex_fwd_en, rd_p0, bus.alu_result_in,
                      bus.mem_reg_wr_in, bus.mem_rd_in, bus.mem_data_in,
                      bus.wb_reg_wr_in, bus.wb_rd_in, bus.wb_data_in);
    fwd_rs2 = forward(bus.dec_rs2_in, bus.dec_rs2_data_in,
                      ex_fwd_en, rd_p0, bus.alu_result_in,
                      bus.mem_reg_wr_in, bus.mem_rd_in, bus.mem_data_in,
                      bus.wb_reg_wr_in, bus.wb_rd_in, bus.wb_data_in);
    op1_nxt = bus.dec_op1_sel_in ? bus.dec_pc_in  : fwd_rs1;
    op2_nxt = bus.dec_op2_sel_in ? bus.dec_imm_in : fwd_rs2;
  end

  // A flush during a load-use hazard still consumes the instruction.
  assign take_bubble       = bus.flush_in | load_use | ~bus.dec_valid_in;
  assign bus.dec_ready_out = bus.ex_ready_in & (~load_use | bus.flush_in);
  assign bus.load_use_stall_out = load_use;

  // ---- decode -> execute boundary (p0) ----
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      vld_p0     <= 1'b0;
      opcode_p0  <= OP_NOP;
      op1_p0     <= '0;
      op2_p0     <= '0;
      store_p0   <= '0;
      rd_p0      <= '0;
      reg_wr_p0  <= 1'b0;
      is_load_p0 <= 1'b0;
    end else if (bus.ex_ready_in) begin
      if (take_bubble) begin
        vld_p0     <= 1'b0;
        opcode_p0  <= OP_NOP;
        op1_p0     <= '0;
        op2_p0     <= '0;
        store_p0   <= '0;
        rd_p0      <= '0;
        reg_wr_p0  <= 1'b0;
        is_load_p0 <= 1'b0;
      end else begin
        vld_p0     <= 1'b1;
        opcode_p0  <= bus.dec_alu_op_in;
        op1_p0     <= op1_nxt;
        op2_p0     <= op2_nxt;
        store_p0   <= fwd_rs2;
        rd_p0      <= bus.dec_rd_in;
        reg_wr_p0  <= bus.dec_reg_wr_in;
        is_load_p0 <= bus.dec_is_load_in;
      end
    end
  end

  assign bus.ex_valid_out      = vld_p0;
  assign bus.alu_opcode_out    = opcode_p0;
  assign bus.alu_op_1_out      = op1_p0;
  assign bus.alu_op_2_out      = op2_p0;
  assign bus.ex_store_data_out = store_p0;
  assign bus.ex_rd_out         = rd_p0;
  assign bus.ex_reg_wr_out     = reg_wr_p0;
  assign bus.ex_is_load_out    = is_load_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a per-cycle behavioural model of the stage.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
  } occ_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) ifc ();
  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .bus       (ifc.slave)
  );

  int   checks = 0;
  int   passed = 0;
  occ_t m = '0;
  occ_t snap;

  function automatic occ_t sample();
    occ_t o;
    o.v  = ifc.ex_valid_out;
    o.op = ifc.alu_opcode_out;
    o.a  = ifc.alu_op_1_out;
    o.b  = ifc.alu_op_2_out;
    o.sd = ifc.ex_store_data_out;
    o.rd = ifc.ex_rd_out;
    o.wr = ifc.ex_reg_wr_out;
    o.ld = ifc.ex_is_load_out;
    return o;
  endfunction

  // Model: scan producers from youngest to oldest, first writer of rs wins.
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    logic [4:0]  prd[3];
    logic        pen[3];
    logic [31:0] pdat[3];
    prd[0] = m.rd;          pen[0] = m.v && m.wr && !m.ld; pdat[0] = ifc.alu_result_in;
    prd[1] = ifc.mem_rd_in; pen[1] = ifc.mem_reg_wr_in;    pdat[1] = ifc.mem_data_in;
    prd[2] = ifc.wb_rd_in;  pen[2] = ifc.wb_reg_wr_in;     pdat[2] = ifc.wb_data_in;
    if (rs == 5'd0) return rf;
    for (int i = 0; i < 3; i++)
      if (pen[i] && prd[i] == rs) return pdat[i];
    return rf;
  endfunction

  function automatic logic m_load_use();
    logic needs;
    needs = (ifc.dec_rs1_used_in && ifc.dec_rs1_in == m.rd) ||
            (ifc.dec_rs2_used_in && ifc.dec_rs2_in == m.rd);
    return ifc.dec_valid_in && m.v && m.ld && m.wr && (m.rd != 5'd0) && needs;
  endfunction

  function automatic occ_t m_next();
    occ_t r;
    if (!rst_n) return '0;
    if (!ifc.ex_ready_in) return m;
    if (ifc.flush_in || m_load_use() || !ifc.dec_valid_in) return '0;
    r.v  = 1'b1;
    r.op = ifc.dec_alu_op_in;
    r.a  = ifc.dec_op1_sel_in ? ifc.dec_pc_in : m_fwd(ifc.dec_rs1_in, ifc.dec_rs1_data_in);
    r.b  = ifc.dec_op2_sel_in ? ifc.dec_imm_in : m_fwd(ifc.dec_rs2_in, ifc.dec_rs2_data_in);
    r.sd = m_fwd(ifc.dec_rs2_in, ifc.dec_rs2_data_in);
    r.rd = ifc.dec_rd_in;
    r.wr = ifc.dec_reg_wr_in;
    r.ld = ifc.dec_is_load_in;
    return r;
  endfunction

  // One clock: compare combinational outputs, advance, compare registered state.
  task automatic tick(input string tag);
    occ_t nxt;
    logic lu;
    logic rdy;
    #1;
    lu  = m_load_use();
    rdy = ifc.ex_ready_in && (!lu || ifc.flush_in);
    checks++;
    if (ifc.load_use_stall_out !== lu)
      $display("FAIL %s load_use got %b exp %b", tag, ifc.load_use_stall_out, lu);
    else passed++;
    checks++;
    if (ifc.dec_ready_out !== rdy)
      $display("FAIL %s dec_ready got %b exp %b", tag, ifc.dec_ready_out, rdy);
    else passed++;
    nxt = m_next();
    @(posedge clk);
    #1;
    m = nxt;
    checks++;
    if (sample() !== m)
      $display("FAIL %s occupant got %h exp %h", tag, sample(), m);
    else passed++;
  endtask

  task automatic clear_side();
    ifc.flush_in      = 1'b0;
    ifc.ex_ready_in   = 1'b1;
    ifc.alu_result_in = '0;
    ifc.mem_rd_in     = '0;
    ifc.mem_reg_wr_in = 1'b0;
    ifc.mem_data_in   = '0;
    ifc.wb_rd_in      = '0;
    ifc.wb_reg_wr_in  = 1'b0;
    ifc.wb_data_in    = '0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic s1, input logic s2,
                           input logic [4:0] rd, input logic wr, input logic ld);
    ifc.dec_valid_in    = 1'b1;
    ifc.dec_alu_op_in   = op;
    ifc.dec_rs1_in      = rs1;
    ifc.dec_rs2_in      = rs2;
    ifc.dec_rs1_used_in = u1;
    ifc.dec_rs2_used_in = u2;
    ifc.dec_rs1_data_in = d1;
    ifc.dec_rs2_data_in = d2;
    ifc.dec_imm_in      = imm;
    ifc.dec_pc_in       = pc;
    ifc.dec_op1_sel_in  = s1;
    ifc.dec_op2_sel_in  = s2;
    ifc.dec_rd_in       = rd;
    ifc.dec_reg_wr_in   = wr;
    ifc.dec_is_load_in  = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_side();
    set_instr(4'b0000, 5'd1, 5'd2, 1, 1, 32'h5, 32'h6, 32'h7, 32'h100, 0, 1, 5'd1, 1, 0);
    @(posedge clk);
    #1;
    m = '0;
    tick("reset0");
    tick("reset1");
    checks++;
    if (sample() !== '0) $display("FAIL reset_outputs got %h exp 0", sample());
    else passed++;
    rst_n = 1'b1;
    tick("first_capture");
    checks++;
    if (ifc.alu_op_1_out !== 32'h5 || ifc.alu_op_2_out !== 32'h7 || ifc.ex_valid_out !== 1'b1)
      $display("FAIL first_capture got op1=%h op2=%h v=%b exp 5 7 1",
               ifc.alu_op_1_out, ifc.alu_op_2_out, ifc.ex_valid_out);
    else passed++;
  endtask

  task automatic test_ex_forward();
    set_instr(4'b0000, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 32'h0, 32'h104, 0, 0, 5'd3, 1, 0);
    tick("add_x3");
    set_instr(4'b1000, 5'd3, 5'd2, 1, 1, 32'h99, 32'h4, 32'h0, 32'h108, 0, 0, 5'd7, 1, 0);
    ifc.alu_result_in = 32'h10;
    tick("sub_fwd");
    checks++;
    if (ifc.alu_op_1_out !== 32'h10 || ifc.alu_opcode_out !== 4'b1000)
      $display("FAIL ex_forward got op1=%h opc=%b exp 10 1000", ifc.alu_op_1_out, ifc.alu_opcode_out);
    else passed++;
    clear_side();
  endtask

  task automatic test_mem_wb_forward();
    set_instr(4'b0110, 5'd4, 5'd0, 1, 0, 32'h44, 32'h0, 32'h0, 32'h10c, 0, 1, 5'd8, 1, 0);
    ifc.mem_rd_in = 5'd4; ifc.mem_reg_wr_in = 1'b1; ifc.mem_data_in = 32'h20;
    ifc.wb_rd_in  = 5'd4; ifc.wb_reg_wr_in  = 1'b1; ifc.wb_data_in  = 32'h30;
    tick("mem_over_wb");
    checks++;
    if (ifc.alu_op_1_out !== 32'h20) $display("FAIL mem_over_wb got %h exp 20", ifc.alu_op_1_out);
    else passed++;
    ifc.mem_reg_wr_in = 1'b0;
    set_instr(4'b0110, 5'd4, 5'd0, 1, 0, 32'h44, 32'h0, 32'h0, 32'h110, 0, 1, 5'd0, 1, 0);
    tick("wb_only");
    checks++;
    if (ifc.alu_op_1_out !== 32'h30) $display("FAIL wb_only got %h exp 30", ifc.alu_op_1_out);
    else passed++;
    set_instr(4'b0000, 5'd0, 5'd0, 1, 1, 32'h12, 32'h0, 32'h0, 32'h114, 0, 0, 5'd9, 0, 0);
    ifc.mem_rd_in = 5'd0; ifc.mem_reg_wr_in = 1'b1; ifc.mem_data_in = 32'hFF;
    ifc.wb_rd_in  = 5'd0; ifc.wb_data_in = 32'hFF;
    ifc.alu_result_in = 32'hEE;
    tick("x0_no_fwd");
    checks++;
    if (ifc.alu_op_1_out !== 32'h12) $display("FAIL x0_no_fwd got %h exp 12", ifc.alu_op_1_out);
    else passed++;
    clear_side();
  endtask

  task automatic test_load_use();
    set_instr(4'b0000, 5'd1, 5'd0, 1, 0, 32'h200, 32'h0, 32'h4, 32'h118, 0, 1, 5'd5, 1, 1);
    tick("lw_x5");
    set_instr(4'b0000, 5'd0, 5'd5, 0, 1, 32'h0, 32'h77, 32'h0, 32'h11c, 0, 0, 5'd10, 1, 0);
    #1;
    checks++;
    if (ifc.load_use_stall_out !== 1'b1 || ifc.dec_ready_out !== 1'b0)
      $display("FAIL load_use_detect got lu=%b rdy=%b exp 1 0", ifc.load_use_stall_out, ifc.dec_ready_out);
    else passed++;
    tick("lu_bubble");
    checks++;
    if (ifc.ex_valid_out !== 1'b0) $display("FAIL lu_bubble got v=%b exp 0", ifc.ex_valid_out);
    else passed++;
    ifc.mem_rd_in = 5'd5; ifc.mem_reg_wr_in = 1'b1; ifc.mem_data_in = 32'hABCD;
    tick("lu_resume");
    checks++;
    if (ifc.alu_op_2_out !== 32'hABCD || ifc.ex_store_data_out !== 32'hABCD || ifc.ex_valid_out !== 1'b1)
      $display("FAIL lu_resume got op2=%h sd=%h v=%b exp abcd abcd 1",
               ifc.alu_op_2_out, ifc.ex_store_data_out, ifc.ex_valid_out);
    else passed++;
    clear_side();
  endtask

  task automatic test_backpressure();
    set_instr(4'b0100, 5'd2, 5'd0, 1, 0, 32'h1234, 32'h0, 32'h0, 32'h120, 0, 0, 5'd11, 1, 0);
    ifc.ex_ready_in = 1'b0;
    snap = sample();
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      checks++;
      if (sample() !== snap || ifc.dec_ready_out !== 1'b0)
        $display("FAIL stall_hold got %h rdy=%b exp %h 0", sample(), ifc.dec_ready_out, snap);
      else passed++;
    end
    ifc.flush_in = 1'b1;
    tick("flush_stalled");
    checks++;
    if (sample() !== snap || ifc.dec_ready_out !== 1'b0)
      $display("FAIL flush_stalled got %h rdy=%b exp %h 0", sample(), ifc.dec_ready_out, snap);
    else passed++;
    ifc.flush_in = 1'b0;
    ifc.ex_ready_in = 1'b1;
    tick("release");
    checks++;
    if (ifc.ex_valid_out !== 1'b1 || ifc.ex_rd_out !== 5'd11 || ifc.alu_op_1_out !== 32'h1234)
      $display("FAIL release got v=%b rd=%0d op1=%h exp 1 11 1234",
               ifc.ex_valid_out, ifc.ex_rd_out, ifc.alu_op_1_out);
    else passed++;
    ifc.dec_valid_in = 1'b0;
    tick("captured_once");
    checks++;
    if (ifc.ex_valid_out !== 1'b0) $display("FAIL captured_once got v=%b exp 0", ifc.ex_valid_out);
    else passed++;
  endtask

  task automatic test_flush();
    set_instr(4'b0111, 5'd1, 5'd2, 1, 1, 32'h3, 32'h5, 32'h0, 32'h124, 0, 0, 5'd12, 1, 0);
    tick("pre_flush");
    set_instr(4'b0110, 5'd1, 5'd2, 1, 1, 32'h3, 32'h5, 32'h0, 32'h128, 0, 0, 5'd13, 1, 0);
    ifc.flush_in = 1'b1;
    #1;
    checks++;
    if (ifc.dec_ready_out !== 1'b1) $display("FAIL flush_ready got %b exp 1", ifc.dec_ready_out);
    else passed++;
    tick("flush");
    checks++;
    if (ifc.ex_valid_out !== 1'b0) $display("FAIL flush_drop got v=%b exp 0", ifc.ex_valid_out);
    else passed++;
    ifc.flush_in = 1'b0;
    set_instr(4'b0000, 5'd1, 5'd0, 1, 0, 32'h300, 32'h0, 32'h8, 32'h12c, 0, 1, 5'd6, 1, 1);
    tick("lw_x6");
    set_instr(4'b0000, 5'd6, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h130, 0, 1, 5'd14, 1, 0);
    ifc.flush_in = 1'b1;
    #1;
    checks++;
    if (ifc.load_use_stall_out !== 1'b1 || ifc.dec_ready_out !== 1'b1)
      $display("FAIL flush_lu got lu=%b rdy=%b exp 1 1", ifc.load_use_stall_out, ifc.dec_ready_out);
    else passed++;
    tick("flush_lu");
    ifc.flush_in = 1'b0;
    set_instr(4'b0000, 5'd1, 5'd0, 1, 0, 32'h9, 32'h0, 32'h1, 32'h134, 0, 1, 5'd15, 1, 0);
    tick("after_flush_lu");
    checks++;
    if (ifc.ex_valid_out !== 1'b1 || ifc.ex_rd_out !== 5'd15)
      $display("FAIL no_extra_bubble got v=%b rd=%0d exp 1 15", ifc.ex_valid_out, ifc.ex_rd_out);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) >= 3);
      set_instr(4'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 99) < 30));
      ifc.dec_valid_in  = ($urandom_range(0, 99) < 80);
      ifc.flush_in      = ($urandom_range(0, 99) < 10);
      ifc.ex_ready_in   = ($urandom_range(0, 99) < 75);
      ifc.alu_result_in = $urandom;
      ifc.mem_rd_in     = 5'($urandom_range(0, 3));
      ifc.mem_reg_wr_in = 1'($urandom);
      ifc.mem_data_in   = $urandom;
      ifc.wb_rd_in      = 5'($urandom_range(0, 3));
      ifc.wb_reg_wr_in  = 1'($urandom);
      ifc.wb_data_in    = $urandom;
      tick("random");
    end
    rst_n = 1'b1;
    clear_side();
  endtask

  initial begin
    clear_side();
    ifc.dec_valid_in = 1'b0;
    test_reset();
    test_ex_forward();
    test_mem_wb_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
